// File: rtl/mbus_pkg.sv
// Shared mbus encodings and address decode for the memory responder.
package mbus_pkg;

    localparam logic MBUS_RESP_OKAY   = 1'b0;
    localparam logic MBUS_RESP_DECERR = 1'b1;

    typedef struct packed {
        logic        in_range;
        logic [31:0] index;
    } word_loc_t;

    // Word index is the byte address above bit 1; anything above the array is out of range.
    function automatic word_loc_t decode_addr(input logic [63:0] addr, input int unsigned depth_bits);
        word_loc_t loc;
        loc.index    = 32'((addr >> 2) & ((64'd1 << depth_bits) - 64'd1));
        loc.in_range = (addr >> (depth_bits + 2)) == 64'd0;
        return loc;
    endfunction

endpackage

// File: rtl/mbus_resp_fifo.sv
// Synchronous FIFO with a combinational head; head reads zero while empty.
module mbus_resp_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam logic [DEPTH_BITS:0] PTR_ONE = (DEPTH_BITS + 1)'(1);

    logic [WIDTH-1:0]  store [1 << DEPTH_BITS];
    logic [DEPTH_BITS:0] wr_ptr;
    logic [DEPTH_BITS:0] rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                     (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
    assign rd_data = empty ? '0 : store[rd_ptr[DEPTH_BITS-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) store[wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mbus_mem_responder.sv
// mbus memory endpoint: in-order reads with fixed latency, byte-strobed single-beat writes.
module mbus_mem_responder
    import mbus_pkg::*;
#(
    parameter int MBUS_ADDR_WIDTH = 32,
    parameter int MBUS_DATA_WIDTH = 32,
    parameter int MBUS_DW_B       = MBUS_DATA_WIDTH >> 3,
    parameter int MEM_DEPTH_BITS  = 10,
    parameter int RD_LATENCY      = 2,
    parameter int Q_DEPTH_BITS    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MBUS_ADDR_WIDTH-1:0] mbus_ar_addr,
    input  logic                       mbus_ar_valid,
    output logic                       mbus_ar_ready,
    output logic [MBUS_DATA_WIDTH-1:0] mbus_r_data,
    output logic                       mbus_r_valid,
    input  logic                       mbus_r_ready,
    input  logic [MBUS_ADDR_WIDTH-1:0] mbus_aw_addr,
    input  logic                       mbus_aw_valid,
    output logic                       mbus_aw_ready,
    input  logic [MBUS_DATA_WIDTH-1:0] mbus_w_data,
    input  logic                       mbus_w_valid,
    input  logic [MBUS_DW_B-1:0]       mbus_w_strb,
    output logic                       mbus_b_resp,
    output logic                       mbus_b_valid,
    input  logic                       mbus_b_ready
);

    localparam logic [Q_DEPTH_BITS:0] OUT_ONE = (Q_DEPTH_BITS + 1)'(1);
    localparam logic [Q_DEPTH_BITS:0] OUT_MAX = OUT_ONE << Q_DEPTH_BITS;

    logic [MBUS_DATA_WIDTH-1:0] mem [1 << MEM_DEPTH_BITS];

    word_loc_t                 ar_loc;
    word_loc_t                 aw_loc;
    logic [MEM_DEPTH_BITS-1:0] ar_idx;
    logic [MEM_DEPTH_BITS-1:0] aw_idx;
    logic                      unused_idx_bits;

    assign ar_loc          = decode_addr(64'(mbus_ar_addr), MEM_DEPTH_BITS);
    assign aw_loc          = decode_addr(64'(mbus_aw_addr), MEM_DEPTH_BITS);
    assign ar_idx          = ar_loc.index[MEM_DEPTH_BITS-1:0];
    assign aw_idx          = aw_loc.index[MEM_DEPTH_BITS-1:0];
    assign unused_idx_bits = ^{ar_loc.index[31:MEM_DEPTH_BITS], aw_loc.index[31:MEM_DEPTH_BITS]};

    logic [Q_DEPTH_BITS:0]      outstanding;
    logic                       ar_fire;
    logic                       r_pop;
    logic                       aw_fire;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       fifo_wr;
    logic [MBUS_DATA_WIDTH-1:0] fifo_wdata;
    logic [MBUS_DATA_WIDTH-1:0] rd_word;

    assign mbus_ar_ready = ~rst & (outstanding < OUT_MAX);
    assign mbus_aw_ready = ~rst & (~mbus_b_valid | mbus_b_ready);
    assign ar_fire       = mbus_ar_valid & mbus_ar_ready;
    assign aw_fire       = mbus_aw_valid & mbus_w_valid & mbus_aw_ready;
    assign mbus_r_valid  = ~fifo_empty;
    assign r_pop         = mbus_r_valid & mbus_r_ready;
    assign rd_word       = ar_loc.in_range ? mem[ar_idx] : '0;

    // NOTE: non-blocking writes mean a read sampled on the same edge sees the pre-write word.
    always_ff @(posedge clk) begin
        if (aw_fire && aw_loc.in_range) begin
            for (int i = 0; i < MBUS_DW_B; i++) begin
                if (mbus_w_strb[i]) mem[aw_idx][8*i +: 8] <= mbus_w_data[8*i +: 8];
            end
        end
    end

    // Credits cover both the pipeline and the FIFO, so the FIFO can never overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (ar_fire && !r_pop) begin
            outstanding <= outstanding + OUT_ONE;
        end else if (!ar_fire && r_pop) begin
            outstanding <= outstanding - OUT_ONE;
        end
    end

    if (RD_LATENCY == 1) begin : g_no_pipe
        assign fifo_wr    = ar_fire;
        assign fifo_wdata = rd_word;
    end else begin : g_pipe
        logic [RD_LATENCY-2:0]      pipe_v;
        logic [MBUS_DATA_WIDTH-1:0] pipe_d [RD_LATENCY-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_v <= '0;
            end else begin
                pipe_v[0] <= ar_fire;
                for (int i = 1; i < RD_LATENCY - 1; i++) pipe_v[i] <= pipe_v[i-1];
            end
        end

        always_ff @(posedge clk) begin
            pipe_d[0] <= rd_word;
            for (int i = 1; i < RD_LATENCY - 1; i++) pipe_d[i] <= pipe_d[i-1];
        end

        assign fifo_wr    = pipe_v[RD_LATENCY-2];
        assign fifo_wdata = pipe_d[RD_LATENCY-2];
    end

    mbus_resp_fifo #(
        .WIDTH      (MBUS_DATA_WIDTH),
        .DEPTH_BITS (Q_DEPTH_BITS)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (r_pop),
        .rd_data (mbus_r_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mbus_b_valid <= 1'b0;
            mbus_b_resp  <= MBUS_RESP_OKAY;
        end else if (aw_fire) begin
            mbus_b_valid <= 1'b1;
            mbus_b_resp  <= aw_loc.in_range ? MBUS_RESP_OKAY : MBUS_RESP_DECERR;
        end else if (mbus_b_ready) begin
            mbus_b_valid <= 1'b0;
        end
    end

    a_no_fifo_overflow : assert property (@(posedge clk) disable iff (rst) !(fifo_wr && fifo_full));

endmodule
